// File: rtl/palette_ram_arbiter.sv
// palette_ram_arbiter: 32x6 palette RAM shared by renderer lookups and buffered CPU accesses
module palette_ram_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pix_req,
    input  logic [4:0] pix_addr,
    input  logic       grayscale,
    output logic [5:0] pix_index,
    output logic       pix_valid,
    input  logic       cpu_wr_req,
    input  logic       cpu_rd_req,
    input  logic [4:0] cpu_addr,
    input  logic [5:0] cpu_wdata,
    output logic       cpu_busy,
    output logic       cpu_ack,
    output logic [5:0] cpu_rdata
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nx;
    logic [5:0] mem [32];
    logic       op_wr;
    logic [4:0] op_addr;
    logic [5:0] op_data;
    logic [7:0] wait_cnt;
    logic       forced, cpu_go, pix_go, strobe;

    // sprite backdrop entries alias the background backdrop entries
    function automatic logic [4:0] eff(input logic [4:0] a);
        return (a[4] && a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
    endfunction

    always_comb begin
        forced   = state == WAIT && wait_cnt == 8'(STARVE_LIMIT);
        cpu_go   = state == WAIT && (!pix_req || forced);
        pix_go   = pix_req && !forced;
        strobe   = state == IDLE && (cpu_wr_req || cpu_rd_req);
        state_nx = strobe ? WAIT : cpu_go ? IDLE : state;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;

    assign cpu_busy = state == WAIT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            pix_index <= '0;
            pix_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            wait_cnt  <= '0;
            op_wr     <= 1'b0;
            op_addr   <= '0;
            op_data   <= '0;
        end else begin
            pix_valid <= pix_go;
            cpu_ack   <= cpu_go;
            if (pix_go) pix_index <= grayscale ? mem[eff(pix_addr)] & 6'h30 : mem[eff(pix_addr)];
            // a write strobe wins over a simultaneous read strobe
            if (strobe) begin
                op_wr   <= cpu_wr_req;
                op_addr <= eff(cpu_addr);
                op_data <= cpu_wdata;
            end
            if (cpu_go) begin
                wait_cnt <= '0;
                if (op_wr) mem[op_addr] <= op_data;
                else cpu_rdata <= mem[op_addr];
            end else if (state == WAIT && wait_cnt < 8'(STARVE_LIMIT)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_palette_ram_arbiter.sv
// tb_palette_ram_arbiter: directed scenarios plus random traffic checked against a transaction-level model
module tb_palette_ram_arbiter;
    localparam int LIM = 8;
    logic clk = 0, reset_n = 0;
    logic pix_req = 0, grayscale = 0, cpu_wr_req = 0, cpu_rd_req = 0;
    logic [4:0] pix_addr = 0, cpu_addr = 0;
    logic [5:0] cpu_wdata = 0;
    logic [5:0] pix_index, cpu_rdata;
    logic pix_valid, cpu_busy, cpu_ack;
    int cnt_total = 0, cnt_bad = 0;

    palette_ram_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset_n(reset_n), .pix_req(pix_req), .pix_addr(pix_addr),
        .grayscale(grayscale), .pix_index(pix_index), .pix_valid(pix_valid),
        .cpu_wr_req(cpu_wr_req), .cpu_rd_req(cpu_rd_req), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata)
    );

    always #5 clk = ~clk;

    // reference model: pending CPU transaction plus count of cycles it has been refused
    logic [5:0] m_mem [32];
    bit m_pend, m_wr;
    logic [4:0] m_a;
    logic [5:0] m_d;
    int m_blk;
    logic [5:0] e_idx, e_rdata;
    bit e_valid, e_ack;

    function automatic logic [4:0] map_addr(input logic [4:0] a);
        int v = int'(a);
        return (v >= 16 && v % 4 == 0) ? 5'(v - 16) : a;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 0;
        m_pend = 0; m_wr = 0; m_a = 0; m_d = 0; m_blk = 0;
        e_idx = 0; e_rdata = 0; e_valid = 0; e_ack = 0;
    endtask

    task automatic model_edge();
        bit was = m_pend;
        bit cpu_now = m_pend && (!pix_req || m_blk == LIM);
        bit pix_now = pix_req && !cpu_now;
        e_ack = cpu_now;
        e_valid = pix_now;
        if (pix_now) e_idx = m_mem[map_addr(pix_addr)] & (grayscale ? 6'h30 : 6'h3F);
        if (cpu_now) begin
            if (m_wr) m_mem[m_a] = m_d;
            else e_rdata = m_mem[m_a];
            m_pend = 0;
        end else if (m_pend) m_blk++;
        if (!was && (cpu_wr_req || cpu_rd_req)) begin
            m_pend = 1; m_blk = 0; m_wr = cpu_wr_req; m_a = map_addr(cpu_addr); m_d = cpu_wdata;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 0;
        model_reset();
        @(posedge clk); #1;
        reset_n = 1;
    endtask

    task automatic cpu_op(input bit wr, input logic [4:0] a, input logic [5:0] d, output int cyc);
        cpu_wr_req = wr; cpu_rd_req = !wr; cpu_addr = a; cpu_wdata = d;
        tick();
        cpu_wr_req = 0; cpu_rd_req = 0;
        cyc = 1;
        while (!cpu_ack && cyc < 40) begin tick(); cyc++; end
        cnt_total++;
        if (!cpu_ack) begin cnt_bad++; $display("FAIL cpu_op_timeout addr=%h cycles=%0d", a, cyc); end
    endtask

    task automatic pix_read(input logic [4:0] a);
        pix_req = 1; pix_addr = a;
        tick();
        pix_req = 0;
    endtask

    task automatic test_reset();
        int c, acks;
        do_reset();
        cnt_total += 5;
        if (pix_index !== 0) begin cnt_bad++; $display("FAIL rst_index got=%h want=0", pix_index); end
        if (pix_valid !== 0) begin cnt_bad++; $display("FAIL rst_valid got=%b want=0", pix_valid); end
        if (cpu_busy !== 0) begin cnt_bad++; $display("FAIL rst_busy got=%b want=0", cpu_busy); end
        if (cpu_ack !== 0) begin cnt_bad++; $display("FAIL rst_ack got=%b want=0", cpu_ack); end
        if (cpu_rdata !== 0) begin cnt_bad++; $display("FAIL rst_rdata got=%h want=0", cpu_rdata); end
        cpu_op(1, 5'h02, 6'h11, c);
        pix_read(5'h02);
        cnt_total++;
        if (pix_index !== 6'h11) begin cnt_bad++; $display("FAIL rst_pre_index got=%h want=11", pix_index); end
        pix_req = 1; pix_addr = 5'h02; cpu_wr_req = 1; cpu_addr = 5'h04; cpu_wdata = 6'h03;
        tick();
        cpu_wr_req = 0;
        tick();
        cnt_total++;
        if (cpu_busy !== 1) begin cnt_bad++; $display("FAIL rst_wait_busy got=%b want=1", cpu_busy); end
        reset_n = 0;
        model_reset();
        #2;
        cnt_total += 4;
        if (pix_index !== 0) begin cnt_bad++; $display("FAIL rst_async_index got=%h want=0", pix_index); end
        if (pix_valid !== 0) begin cnt_bad++; $display("FAIL rst_async_valid got=%b want=0", pix_valid); end
        if (cpu_busy !== 0) begin cnt_bad++; $display("FAIL rst_async_busy got=%b want=0", cpu_busy); end
        if (cpu_ack !== 0) begin cnt_bad++; $display("FAIL rst_async_ack got=%b want=0", cpu_ack); end
        @(posedge clk); #1;
        reset_n = 1; pix_req = 0;
        acks = 0;
        for (int i = 0; i < 12; i++) begin tick(); acks += int'(cpu_ack); end
        cnt_total++;
        if (acks != 0) begin cnt_bad++; $display("FAIL rst_stale_ack got=%0d want=0", acks); end
        pix_read(5'h00);
        cnt_total += 2;
        if (pix_index !== 0 || pix_valid !== 1) begin cnt_bad++; $display("FAIL rst_pix0 got=%h/%b want=00/1", pix_index, pix_valid); end
        pix_read(5'h04);
        if (pix_index !== 0) begin cnt_bad++; $display("FAIL rst_discarded_write got=%h want=0", pix_index); end
    endtask

    task automatic test_mirror();
        int c;
        pix_req = 0; cpu_wr_req = 1; cpu_addr = 5'h10; cpu_wdata = 6'h2A;
        tick();
        cpu_wr_req = 0;
        cnt_total++;
        if (cpu_busy !== 1 || cpu_ack !== 0) begin cnt_bad++; $display("FAIL mir_capture got busy=%b ack=%b want 1/0", cpu_busy, cpu_ack); end
        tick();
        cnt_total++;
        if (cpu_ack !== 1 || cpu_busy !== 0) begin cnt_bad++; $display("FAIL mir_ack got ack=%b busy=%b want 1/0", cpu_ack, cpu_busy); end
        pix_read(5'h00);
        cnt_total++;
        if (pix_index !== 6'h2A) begin cnt_bad++; $display("FAIL mir_read00 got=%h want=2a", pix_index); end
        pix_read(5'h10);
        cnt_total++;
        if (pix_index !== 6'h2A) begin cnt_bad++; $display("FAIL mir_read10 got=%h want=2a", pix_index); end
        cpu_op(1, 5'h11, 6'h05, c);
        pix_read(5'h01);
        cnt_total++;
        if (pix_index !== 6'h00) begin cnt_bad++; $display("FAIL mir_read01 got=%h want=00", pix_index); end
        pix_read(5'h11);
        cnt_total++;
        if (pix_index !== 6'h05) begin cnt_bad++; $display("FAIL mir_read11 got=%h want=05", pix_index); end
    endtask

    task automatic test_starvation();
        int c, invalid;
        logic [5:0] held;
        pix_req = 1; pix_addr = 5'h11;
        tick();
        pix_req = 1; cpu_wr_req = 1; cpu_addr = 5'h03; cpu_wdata = 6'h16;
        tick();
        cpu_wr_req = 0;
        c = 1; invalid = 0; held = 0;
        while (!cpu_ack && c < 40) begin
            tick(); c++;
            if (!pix_valid) begin invalid++; held = pix_index; end
        end
        cnt_total += 3;
        if (c != LIM + 2) begin cnt_bad++; $display("FAIL starve_latency got=%0d want=%0d", c, LIM + 2); end
        if (invalid != 1) begin cnt_bad++; $display("FAIL starve_gap got=%0d want=1", invalid); end
        if (held !== 6'h05) begin cnt_bad++; $display("FAIL starve_hold got=%h want=05", held); end
        pix_read(5'h03);
        cnt_total++;
        if (pix_index !== 6'h16) begin cnt_bad++; $display("FAIL starve_data got=%h want=16", pix_index); end
    endtask

    task automatic test_greyscale();
        int c;
        pix_req = 0;
        cpu_op(1, 5'h05, 6'h27, c);
        grayscale = 1;
        pix_read(5'h05);
        cnt_total++;
        if (pix_index !== 6'h20) begin cnt_bad++; $display("FAIL grey_on got=%h want=20", pix_index); end
        cpu_op(0, 5'h05, 6'h00, c);
        cnt_total++;
        if (cpu_rdata !== 6'h27) begin cnt_bad++; $display("FAIL grey_rdata got=%h want=27", cpu_rdata); end
        grayscale = 0;
        pix_read(5'h05);
        cnt_total++;
        if (pix_index !== 6'h27) begin cnt_bad++; $display("FAIL grey_off got=%h want=27", pix_index); end
    endtask

    task automatic test_collision();
        int acks;
        pix_req = 0; cpu_wr_req = 1; cpu_rd_req = 1; cpu_addr = 5'h06; cpu_wdata = 6'h3B;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick(); cpu_wr_req = 0; cpu_rd_req = 0; acks += int'(cpu_ack);
        end
        cnt_total += 2;
        if (acks != 1) begin cnt_bad++; $display("FAIL coll_acks got=%0d want=1", acks); end
        if (cpu_rdata !== 6'h27) begin cnt_bad++; $display("FAIL coll_rdata_hold got=%h want=27", cpu_rdata); end
        pix_read(5'h06);
        cnt_total++;
        if (pix_index !== 6'h3B) begin cnt_bad++; $display("FAIL coll_write got=%h want=3b", pix_index); end
        pix_req = 1; pix_addr = 5'h00; cpu_wr_req = 1; cpu_addr = 5'h07; cpu_wdata = 6'h12;
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            cpu_wr_req = (i == 2 || i == 5); cpu_wdata = 6'h3F;
            acks += int'(cpu_ack);
        end
        cpu_wr_req = 0;
        pix_read(5'h07);
        cnt_total += 2;
        if (acks != 1) begin cnt_bad++; $display("FAIL busy_acks got=%0d want=1", acks); end
        if (pix_index !== 6'h12) begin cnt_bad++; $display("FAIL busy_ignored got=%h want=12", pix_index); end
    endtask

    task automatic test_back_to_back();
        int n;
        pix_req = 0; cpu_wr_req = 1; cpu_addr = 5'h08; cpu_wdata = 6'h0A;
        tick();
        cpu_wr_req = 0;
        tick();
        cnt_total++;
        if (cpu_ack !== 1) begin cnt_bad++; $display("FAIL b2b_first_ack got=%b want=1", cpu_ack); end
        cpu_wr_req = 1; cpu_addr = 5'h09; cpu_wdata = 6'h0B;
        tick();
        cpu_wr_req = 0;
        cnt_total++;
        if (cpu_busy !== 1) begin cnt_bad++; $display("FAIL b2b_accept got=%b want=1", cpu_busy); end
        tick();
        cnt_total++;
        if (cpu_ack !== 1) begin cnt_bad++; $display("FAIL b2b_second_ack got=%b want=1", cpu_ack); end
        pix_read(5'h08);
        pix_req = 1; pix_addr = 5'h09;
        cnt_total++;
        if (pix_index !== 6'h0A) begin cnt_bad++; $display("FAIL b2b_data8 got=%h want=0a", pix_index); end
        tick();
        pix_req = 0;
        cnt_total++;
        if (pix_index !== 6'h0B) begin cnt_bad++; $display("FAIL b2b_data9 got=%h want=0b", pix_index); end
        n = 0;
        for (int i = 0; i < 800; i++) begin
            pix_req = $urandom_range(0, 9) < 7;
            pix_addr = 5'($urandom);
            grayscale = $urandom_range(0, 3) == 0;
            cpu_wr_req = $urandom_range(0, 3) == 0;
            cpu_rd_req = $urandom_range(0, 3) == 0;
            cpu_addr = 5'($urandom);
            cpu_wdata = 6'($urandom);
            tick();
            n += int'(cpu_ack);
            cnt_total += 5;
            if (pix_valid !== e_valid) begin cnt_bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", i, pix_valid, e_valid); end
            if (pix_index !== e_idx) begin cnt_bad++; $display("FAIL rnd_index cyc=%0d got=%h want=%h", i, pix_index, e_idx); end
            if (cpu_ack !== e_ack) begin cnt_bad++; $display("FAIL rnd_ack cyc=%0d got=%b want=%b", i, cpu_ack, e_ack); end
            if (cpu_busy !== m_pend) begin cnt_bad++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", i, cpu_busy, m_pend); end
            if (cpu_rdata !== e_rdata) begin cnt_bad++; $display("FAIL rnd_rdata cyc=%0d got=%h want=%h", i, cpu_rdata, e_rdata); end
        end
        cnt_total++;
        if (n < 20) begin cnt_bad++; $display("FAIL rnd_ack_count got=%0d want>=20", n); end
        cpu_wr_req = 0; cpu_rd_req = 0; pix_req = 0;
    endtask

    initial begin
        model_reset();
        #3;
        test_reset();
        test_mirror();
        test_starvation();
        test_greyscale();
        test_collision();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", cnt_total, cnt_bad);
        $finish;
    end
endmodule
